cdc_req_ack_ctrl: RTL and testbench

- Source-side controller for a 4-phase req/ack handshake that moves one DW-bit word per transaction into a foreign clock domain.
- Accepts words from a local valid/ready requester and holds the word stable on xfer_data for the whole transaction.
- Sequences xfer_req and samples the foreign-domain ack through an internal 3-flop synchronizer.
- Detects a stuck handshake with a timeout counter. Sits at every slow-path control crossing in the SoC.

---
 rtl/cdc_pkg.sv | 17 +
 rtl/sync3_sr.sv | 23 ++
 rtl/cdc_req_ack_ctrl.sv | 133 +++++++++++++
 tb/tb_cdc_req_ack_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the req/ack clock-crossing controller.
package cdc_pkg;

   typedef enum logic [2:0] {
      INIT    = 3'd0,
      IDLE    = 3'd1,
      WAIT_HI = 3'd2,
      WAIT_LO = 3'd3,
      ERR     = 3'd4
   } state_e;

   localparam int SYNC_STAGES = 3;
   localparam int DEF_DW      = 32;
   localparam int DEF_CNT_W   = 10;
   localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/sync3_sr.sv
// Multi-flop single-bit synchronizer with synchronous active-high reset.
module sync3_sr
   import cdc_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_req_ack_ctrl.sv
// Source-side 4-phase req/ack controller carrying one word per transaction
// into a foreign clock domain, with stuck-handshake timeout.
module cdc_req_ack_ctrl
   import cdc_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          xfer_req,
   output logic [DW-1:0] xfer_data,
   input  logic          xfer_ack_async,
   output logic          done,
   output logic          busy,
   output logic          err,
   input  logic          err_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] INIT_WAIT = CNT_W'(SYNC_STAGES);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]     data_q, data_d;
   logic              req_q, req_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ack_s;
   logic              tmo;

   sync3_sr u_ack_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (xfer_ack_async),
      .q_o   (ack_s)
   );

   assign tmo = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = err_q;
      unique case (state_q)
         INIT: begin
            if (cnt_q >= INIT_WAIT && !ack_s) state_d = IDLE;
         end
         IDLE: begin
            if (in_valid) begin
               state_d = WAIT_HI;
               req_d   = 1'b1;
               data_d  = in_data;
            end
         end
         WAIT_HI: begin
            if (ack_s) begin
               state_d = WAIT_LO;
               req_d   = 1'b0;
            end else if (tmo) begin
               state_d = ERR;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end
         end
         WAIT_LO: begin
            if (!ack_s) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (tmo) begin
               state_d = ERR;
               err_d   = 1'b1;
            end
         end
         ERR: begin
            req_d = 1'b0;
            if (err_clr) begin
               state_d = INIT;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = INIT;
            req_d   = 1'b0;
         end
      endcase
   end

   // INIT also counts so the synchronizer holds real samples before exit
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == IDLE || state_q == ERR) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
         data_q  <= '0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         req_q   <= req_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign xfer_req  = req_q;
   assign xfer_data = data_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_cdc_req_ack_ctrl.sv
// Self-checking bench for cdc_req_ack_ctrl: vector table, directed
// sequences and a randomized run against a transaction-level model.
module tb_cdc_req_ack_ctrl;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        xfer_req;
   logic [31:0] xfer_data;
   logic        xfer_ack_async;
   logic        done;
   logic        busy;
   logic        err;
   logic        err_clr;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // foreign-side ack model controls
   logic auto_en = 1'b0;
   logic ack_man = 1'b0;
   logic ack_auto = 1'b0;
   logic fix_en = 1'b1;
   int   fix_dr = 0;
   int   fix_df = 0;
   int   nxt_dr = 0;
   int   nxt_df = 0;
   int   used_dr = 0;
   int   used_df = 0;
   int   wcnt = 0;

   assign xfer_ack_async = auto_en ? ack_auto : ack_man;

   cdc_req_ack_ctrl #(
      .DW      (32),
      .CNT_W   (10),
      .TIMEOUT (16)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .xfer_req       (xfer_req),
      .xfer_data      (xfer_data),
      .xfer_ack_async (xfer_ack_async),
      .done           (done),
      .busy           (busy),
      .err            (err),
      .err_clr        (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Foreign domain: ack follows req after a chosen number of cycles
   always @(negedge clk) begin
      if (!auto_en) begin
         ack_auto <= 1'b0;
         wcnt     <= 0;
      end else if (xfer_req && !ack_auto) begin
         if (wcnt == nxt_dr) begin
            ack_auto <= 1'b1;
            used_dr  <= nxt_dr;
            wcnt     <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else if (!xfer_req && ack_auto) begin
         if (wcnt == nxt_df) begin
            ack_auto <= 1'b0;
            used_df  <= nxt_df;
            wcnt     <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         wcnt   <= 0;
         nxt_dr <= fix_en ? fix_dr : int'($urandom_range(0, 4));
         nxt_df <= fix_en ? fix_df : int'($urandom_range(0, 4));
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic rst;
      logic ack;
      logic clr;
      logic rdy;
      logic bsy;
      logic req;
      logic er;
   } vec_t;

   vec_t tbl [24];

   initial begin
      logic [31:0] w [3];
      logic [31:0] q [$];
      logic        r;
      logic        acc;
      int          acc_cyc;
      int          dcyc;
      int          ndone;
      int          idx;
      int          last_done;
      int          ecyc;
      int          seen;
      int          lat;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      err_clr  = 1'b0;

      // reset release with ack low, err_clr ignored, then ack held high
      for (int i = 0; i < 24; i++) tbl[i] = '{0, 0, 0, 0, 1, 0, 0};
      for (int i = 0; i < 4; i++) tbl[i].rst = 1'b1;
      for (int i = 7; i < 10; i++) begin
         tbl[i].rdy = 1'b1;
         tbl[i].bsy = 1'b0;
      end
      tbl[8].clr = 1'b1;
      for (int i = 10; i < 13; i++) tbl[i].rst = 1'b1;
      for (int i = 10; i < 19; i++) tbl[i].ack = 1'b1;
      for (int i = 22; i < 24; i++) begin
         tbl[i].rdy = 1'b1;
         tbl[i].bsy = 1'b0;
      end

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         reset   = tbl[i].rst;
         ack_man = tbl[i].ack;
         err_clr = tbl[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("tbl_rdy[%0d]", i), 32'(in_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl_busy[%0d]", i), 32'(busy), 32'(tbl[i].bsy));
         chk($sformatf("tbl_req[%0d]", i), 32'(xfer_req), 32'(tbl[i].req));
         chk($sformatf("tbl_err[%0d]", i), 32'(err), 32'(tbl[i].er));
         chk($sformatf("tbl_done[%0d]", i), 32'(done), 32'd0);
         if (tbl[i].rst) chk($sformatf("tbl_data[%0d]", i), xfer_data, 32'd0);
      end

      // single transfer, ack 2 cycles after req and 2 after req falls
      @(negedge clk);
      err_clr = 1'b0;
      auto_en = 1'b1;
      fix_en  = 1'b1;
      fix_dr  = 2;
      fix_df  = 2;
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      chk("one_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      chk("one_req", 32'(xfer_req), 32'd1);
      chk("one_data", xfer_data, 32'hDEADBEEF);
      ndone = 0;
      dcyc  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = $urandom;
         @(posedge clk);
         #1;
         if (dcyc == 0) chk("one_hold", xfer_data, 32'hDEADBEEF);
         if (done) begin
            ndone++;
            if (dcyc == 0) dcyc = cyc;
         end
      end
      chk("one_done_cnt", 32'(ndone), 32'd1);
      chk("one_latency", 32'(dcyc - acc_cyc), 32'd12);

      // back-to-back words with in_valid held high
      w[0] = 32'h1;
      w[1] = 32'h2;
      w[2] = 32'h3;
      fix_dr    = 1;
      fix_df    = 0;
      idx       = 0;
      ndone     = 0;
      last_done = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         in_valid = (idx < 3);
         if (idx < 3) in_data = w[idx];
         r = in_ready;
         @(posedge clk);
         #1;
         if (in_valid && r) begin
            chk($sformatf("b2b_acc_data[%0d]", idx), xfer_data, w[idx]);
            if (idx > 0) chk($sformatf("b2b_gap[%0d]", idx),
                             32'(cyc - last_done), 32'd1);
            idx++;
         end
         if (done) begin
            if (ndone < 3) chk($sformatf("b2b_done_data[%0d]", ndone),
                               xfer_data, w[ndone]);
            last_done = cyc;
            ndone++;
         end
      end
      in_valid = 1'b0;
      chk("b2b_accepts", 32'(idx), 32'd3);
      chk("b2b_dones", 32'(ndone), 32'd3);

      // timeout: ack never rises
      @(negedge clk);
      auto_en  = 1'b0;
      ack_man  = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0BADF00D;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      ecyc    = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
         #1;
         if (err && ecyc == 0) begin
            ecyc = cyc;
            chk("tmo_req", 32'(xfer_req), 32'd0);
            chk("tmo_ready", 32'(in_ready), 32'd0);
            chk("tmo_busy", 32'(busy), 32'd1);
         end
      end
      chk("tmo_cycles", 32'(ecyc - acc_cyc), 32'd16);
      chk("tmo_sticky", 32'(err), 32'd1);
      @(negedge clk);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_ready", 32'(in_ready), 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         err_clr = 1'b0;
         @(posedge clk);
         #1;
         if (in_ready) seen = 1;
      end
      chk("clr_to_idle", 32'(seen), 32'd1);

      // reset while waiting for ack
      @(negedge clk);
      auto_en  = 1'b1;
      fix_dr   = 2;
      fix_df   = 2;
      in_valid = 1'b1;
      in_data  = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      chk("abort_req_up", 32'(xfer_req), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_req", 32'(xfer_req), 32'd0);
      chk("abort_busy", 32'(busy), 32'd1);
      chk("abort_ready", 32'(in_ready), 32'd0);
      chk("abort_data", xfer_data, 32'd0);
      ndone = 0;
      seen  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         reset = 1'b0;
         @(posedge clk);
         #1;
         if (done) ndone++;
         if (in_ready) seen = 1;
      end
      chk("abort_no_done", 32'(ndone), 32'd0);
      chk("abort_idle", 32'(seen), 32'd1);

      // randomized traffic against a transaction-level model
      fix_en = 1'b0;
      q.delete();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         in_data  = $urandom;
         chk("rnd_ready", 32'(in_ready), 32'(q.size() == 0));
         acc = in_valid && (q.size() == 0);
         @(posedge clk);
         #1;
         if (acc) begin
            q.push_back(in_data);
            acc_cyc = cyc;
         end
         if (done) begin
            chk("rnd_done_inflight", 32'(q.size()), 32'd1);
            if (q.size() != 0) begin
               chk("rnd_done_data", xfer_data, q[0]);
               lat = 8 + used_dr + used_df;
               chk("rnd_latency", 32'(cyc - acc_cyc), 32'(lat));
               void'(q.pop_front());
            end
         end else if (q.size() != 0) begin
            chk("rnd_hold", xfer_data, q[0]);
            if (cyc - acc_cyc > 20) begin
               chk("rnd_stuck", 32'(cyc - acc_cyc), 32'd20);
               q.delete();
            end
         end
         chk("rnd_err", 32'(err), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
